uart_tx_param: RTL

//  Parametrised UART transmitter: serialises one word per request at a programmable
//  bit rate with selectable data width, parity and stop bits.

---
 rtl/uart_tx_param.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Purpose  : Parametrised UART transmitter with baud divider, parity, 1/2 stop
//            bits and a ready/valid request port. Back-to-back capable.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] txbyte,
  input  logic                 senddata,
  output logic                 ready,
  output logic                 busy,
  output logic                 txdone,
  output logic                 tx
);

  localparam int c_baud_w = $clog2(CLKS_PER_BIT);
  localparam int c_bit_w  = $clog2(DATA_BITS);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(DATA_BITS - 1);
  localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_baud_w-1:0]   r_baud;
  logic [c_bit_w-1:0]    r_bit;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_txdone;
  logic                  w_bit_end;

  assign w_bit_end = (r_baud == c_baud_last);
  assign ready     = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state != S_IDLE);
  assign txdone    = r_txdone;
  assign tx        = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_txdone <= 1'b0;
    end else begin
      r_txdone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (senddata) begin
            r_shift  <= txbyte;
            // Odd parity is the complement of the XOR reduction.
            r_parity <= (PARITY == 1) ? ~^txbyte : ^txbyte;
            r_tx     <= 1'b0;
            r_state  <= S_START;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == c_data_last) begin
              r_bit <= '0;
              if (PARITY != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == c_stop_last) begin
              r_bit    <= '0;
              r_txdone <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
